// File: rtl/mult_product_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_product_accum_if : load/product snoop and sum valid/ready bundle       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mult_product_accum_if #(
  parameter int PW    = 12,
  parameter int ACC_W = 16
);
  logic             load;
  logic [PW-1:0]    product;
  logic             clr_acc;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             err;

  modport master (
    output load, product, clr_acc, out_ready,
    input  busy, out_valid, out_sum, out_sat, err
  );

  modport slave (
    input  load, product, clr_acc, out_ready,
    output busy, out_valid, out_sum, out_sat, err
  );
endinterface
`default_nettype wire

// File: rtl/mult_product_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_product_accum : waits out multiplier latency, sums GROUP products      |
// | with saturation and hands each sum downstream on valid/ready. Rev 1.0       |
// +----------------------------------------------------------------------------+
module mult_product_accum #(
  parameter int PW       = 12,
  parameter int MULT_LAT = 6,
  parameter int GROUP    = 4,
  parameter int ACC_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mult_product_accum_if.slave bus
);

  localparam int LW = $clog2(MULT_LAT + 1);
  localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MULT_LAT);
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [GW-1:0]    grp_q, grp_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             pend_sat_q, pend_sat_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_clamped;
  logic             sum_sat;
  logic             out_free;

  // One extra bit catches the carry that triggers clamping.
  assign sum_wide    = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, bus.product};
  assign sum_clamped = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign sum_sat     = sat_q | sum_wide[ACC_W];
  assign out_free    = ~out_valid_q | bus.out_ready;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    grp_d       = grp_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    pend_d      = pend_q;
    pend_sat_d  = pend_sat_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.clr_acc) begin
          acc_d = '0;
          grp_d = '0;
          sat_d = 1'b0;
        end
        if (bus.load) begin
          lat_d   = LW'(1);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.clr_acc) begin
          acc_d = '0;
          grp_d = '0;
          sat_d = 1'b0;
          if (bus.load) lat_d = LW'(1);
          else          state_d = S_IDLE;
        end else begin
          if (bus.load) err_d = 1'b1;
          if (lat_q == LAT_LAST) begin
            if (grp_q == GRP_LAST) begin
              if (out_free) begin
                out_sum_d   = sum_clamped;
                out_sat_d   = sum_sat;
                out_valid_d = 1'b1;
                acc_d       = '0;
                grp_d       = '0;
                sat_d       = 1'b0;
                state_d     = S_IDLE;
              end else begin
                pend_d     = sum_clamped;
                pend_sat_d = sum_sat;
                state_d    = S_HOLD;
              end
            end else begin
              acc_d   = sum_clamped;
              sat_d   = sum_sat;
              grp_d   = grp_q + GW'(1);
              state_d = S_IDLE;
            end
          end else begin
            lat_d = lat_q + LW'(1);
          end
        end
      end

      S_HOLD: begin
        if (bus.load) err_d = 1'b1;
        if (bus.clr_acc) begin
          acc_d = '0;
          grp_d = '0;
          sat_d = 1'b0;
        end
        if (out_free) begin
          out_sum_d   = pend_q;
          out_sat_d   = pend_sat_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          grp_d       = '0;
          sat_d       = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      grp_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      pend_q      <= '0;
      pend_sat_q  <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      grp_q       <= grp_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      pend_q      <= pend_d;
      pend_sat_q  <= pend_sat_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_product_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_product_accum : vector table + scoreboard bench. Rev 1.0            |
// +----------------------------------------------------------------------------+
module tb_mult_product_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // b4: GROUP=4 with a narrow 13-bit sum so saturation is reachable; b1: GROUP=1.
  mult_product_accum_if #(.PW(12), .ACC_W(13)) b4 ();
  mult_product_accum_if #(.PW(12), .ACC_W(16)) b1 ();

  mult_product_accum #(.PW(12), .MULT_LAT(6), .GROUP(4), .ACC_W(13)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  mult_product_accum #(.PW(12), .MULT_LAT(6), .GROUP(1), .ACC_W(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        sat;
  } exp_t;

  typedef struct packed {
    logic [11:0] p0;
    logic [11:0] p1;
    logic [11:0] p2;
    logic [11:0] p3;
    logic [15:0] sum;
    logic        sat;
  } grp_vec_t;

  typedef struct packed {
    logic [11:0] p;
    logic [15:0] sum;
  } one_vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got word %0d, required no word", b4.out_sum);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_sum", 32'(b4.out_sum), 32'(e.sum));
        chk("sb_sat", 32'(b4.out_sat), 32'(e.sat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic t);
    exp_t e;
    e.sum = s;
    e.sat = t;
    sbq.push_back(e);
  endtask

  task automatic wait_idle4();
    int t = 0;
    while (b4.busy && t < 50) begin
      step();
      t++;
    end
    if (b4.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle4_timeout: busy %0d, required 0", b4.busy);
    end
  endtask

  task automatic pulse4(input logic [11:0] p);
    wait_idle4();
    b4.product = p;
    b4.load    = 1'b1;
    step();
    b4.load    = 1'b0;
  endtask

  task automatic lat4(input string name);
    int cnt = 0;
    while (b4.busy && cnt < 30) begin
      step();
      cnt++;
    end
    chk(name, 32'(cnt), 32'd6);
  endtask

  task automatic load4(input logic [11:0] p);
    pulse4(p);
    lat4("lat4");
  endtask

  task automatic drain4();
    int t = 0;
    while (sbq.size() > 0 && t < 50) begin
      step();
      t++;
    end
    chk("drain4_left", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    grp_vec_t gv[8];
    one_vec_t ov[4];
    int       cnt;

    gv[0] = '{12'd1,    12'd2,    12'd3,    12'd4,    16'd10,   1'b0};
    gv[1] = '{12'd3969, 12'd3969, 12'd3969, 12'd3969, 16'd8191, 1'b1};
    gv[2] = '{12'd1,    12'd1,    12'd1,    12'd1,    16'd4,    1'b0};
    gv[3] = '{12'd4095, 12'd4095, 12'd0,    12'd0,    16'd8190, 1'b0};
    gv[4] = '{12'd0,    12'd0,    12'd0,    12'd0,    16'd0,    1'b0};
    gv[5] = '{12'd4095, 12'd4095, 12'd1,    12'd0,    16'd8191, 1'b0};
    gv[6] = '{12'd4095, 12'd4095, 12'd2,    12'd0,    16'd8191, 1'b1};
    gv[7] = '{12'd100,  12'd200,  12'd300,  12'd400,  16'd1000, 1'b0};

    ov[0] = '{12'd3969, 16'd3969};
    ov[1] = '{12'd0,    16'd0};
    ov[2] = '{12'd4095, 16'd4095};
    ov[3] = '{12'd1234, 16'd1234};

    b4.load = 1'b0; b4.product = '0; b4.clr_acc = 1'b0; b4.out_ready = 1'b1;
    b1.load = 1'b0; b1.product = '0; b1.clr_acc = 1'b0; b1.out_ready = 1'b1;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy",  32'(b4.busy),      32'd0);
    chk("rst_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_sum",   32'(b4.out_sum),   32'd0);
    chk("rst_sat",   32'(b4.out_sat),   32'd0);
    chk("rst_err",   32'(b4.err),       32'd0);
    chk("rst_valid1", 32'(b1.out_valid), 32'd0);

    // Group sums, including saturation boundaries and sticky saturation.
    for (int i = 0; i < 8; i++) begin
      push(gv[i].sum, gv[i].sat);
      load4(gv[i].p0);
      load4(gv[i].p1);
      load4(gv[i].p2);
      load4(gv[i].p3);
    end
    drain4();

    // Backpressure: second group parks in HOLD until the first word drains.
    b4.out_ready = 1'b0;
    push(16'd100, 1'b0);
    load4(12'd10); load4(12'd20); load4(12'd30); load4(12'd40);
    push(16'd20, 1'b0);
    load4(12'd5); load4(12'd5); load4(12'd5);
    chk("t5_w1_valid", 32'(b4.out_valid), 32'd1);
    chk("t5_w1_sum",   32'(b4.out_sum),   32'd100);
    pulse4(12'd5);
    repeat (10) step();
    chk("t5_hold_busy",  32'(b4.busy),      32'd1);
    chk("t5_hold_valid", 32'(b4.out_valid), 32'd1);
    chk("t5_hold_sum",   32'(b4.out_sum),   32'd100);
    b4.clr_acc = 1'b1;
    step();
    b4.clr_acc = 1'b0;
    chk("t5_clr_busy", 32'(b4.busy), 32'd1);
    repeat (3) step();
    chk("t5_stable_sum", 32'(b4.out_sum), 32'd100);
    b4.out_ready = 1'b1;
    drain4();
    chk("t5_busy_after", 32'(b4.busy), 32'd0);

    // clr_acc together with load in WAIT restarts and drops the partial sum.
    chk("t6_err_init", 32'(b4.err), 32'd0);
    push(16'd106, 1'b0);
    load4(12'd7);
    load4(12'd8);
    pulse4(12'd9);
    step();
    b4.clr_acc = 1'b1;
    b4.load    = 1'b1;
    b4.product = 12'd100;
    step();
    b4.clr_acc = 1'b0;
    b4.load    = 1'b0;
    lat4("t6_restart_lat");
    chk("t6_err_after_clrload", 32'(b4.err), 32'd0);
    load4(12'd1); load4(12'd2); load4(12'd3);
    drain4();

    // clr_acc alone in WAIT aborts the capture and the partial group.
    load4(12'd11);
    pulse4(12'd999);
    step();
    b4.clr_acc = 1'b1;
    step();
    b4.clr_acc = 1'b0;
    chk("t6_abort_busy", 32'(b4.busy), 32'd0);

    // Load during WAIT cycle 3: flagged, capture timing unchanged.
    push(16'd200, 1'b0);
    pulse4(12'd50);
    step();
    step();
    b4.load = 1'b1;
    step();
    b4.load = 1'b0;
    cnt = 0;
    while (b4.busy && cnt < 30) begin
      step();
      cnt++;
    end
    chk("t6_busy_lat", 32'(cnt), 32'd3);
    chk("t6_err_set", 32'(b4.err), 32'd1);
    load4(12'd50); load4(12'd50); load4(12'd50);
    drain4();
    chk("t6_err_sticky", 32'(b4.err), 32'd1);

    // Reset mid-WAIT with a partial group pending.
    load4(12'd100);
    pulse4(12'd200);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("t1_busy",  32'(b4.busy),      32'd0);
    chk("t1_valid", 32'(b4.out_valid), 32'd0);
    chk("t1_err",   32'(b4.err),       32'd0);
    chk("t1_sum",   32'(b4.out_sum),   32'd0);
    chk("t1_sat",   32'(b4.out_sat),   32'd0);
    push(16'd10, 1'b0);
    load4(12'd1); load4(12'd2); load4(12'd3); load4(12'd4);
    drain4();

    // GROUP=1: out_valid rises exactly MULT_LAT edges after the load edge.
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      while (b1.busy && cnt < 50) begin
        step();
        cnt++;
      end
      chk("t2_idle", 32'(b1.busy), 32'd0);
      b1.product = ov[i].p;
      b1.load    = 1'b1;
      step();
      b1.load    = 1'b0;
      cnt = 0;
      while (!b1.out_valid && cnt < 30) begin
        step();
        cnt++;
      end
      chk("t2_lat", 32'(cnt), 32'd6);
      chk("t2_sum", 32'(b1.out_sum), 32'(ov[i].sum));
      chk("t2_sat", 32'(b1.out_sat), 32'd0);
    end

    step();
    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
